seq_detect_moore_param: RTL and testbench
=========================================

// Module: seq_detect_moore_param
// PURPOSE
//   Parametrised Moore serial sequence detector: matches a PAT_W-bit pattern, runtime-loadable, on a 1-bit stream.
//   Optional overlap, sample enable and saturating match counter. Sits after a serial deserialiser/sampler.
//   Output is decoded from the state register only (no data_in-to-match path).
// PARAMETERS
//   PAT_W    5          pattern length in bits (>=2)
//   PATTERN  5'b11011   reset/default pattern; bit PAT_W-1 is the first bit received
//   OVERLAP  1          1: after a match, matched suffixes carry over; 0: restart from state 0 after a match
//   CNT_W    8          match counter width
//   ST_W     localparam $clog2(PAT_W+1); width of the state index
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   en         in   1      sample enable; data_in is consumed only when en=1
//   data_in    in   1      serial input bit
//   pat_load   in   1      load pat_in as the active pattern
//   pat_in     in   PAT_W  new pattern, MSB first
//   cnt_clr    in   1      clear match_count
//   match      out  1      1 while state==PAT_W (Moore)
//   match_count out CNT_W  saturating number of matches
//   state      out  ST_W   number of pattern bits currently matched (0..PAT_W)
// BEHAVIOUR
// - Reset: state=0, pattern reg=PATTERN, match_count=0, match=0.
// - State k = longest prefix of the pattern that is a suffix of the bits received so far. k=PAT_W is the match state.
// - Next state on en=1 with bit b:
//   - S = first k pattern bits followed by b.
//   - next = largest j<=PAT_W such that the last j bits of S equal the first j pattern bits (KMP-style); 0 if none.
//   - Computed combinationally against the pattern register.
//   - For k=PAT_W with OVERLAP=0, treat k as 0 before computing next.
// - en=0: state, match and count hold; data_in ignored.
// - match=1 in the cycle after the last pattern bit is sampled (1-cycle latency).
//   - Stays high across consecutive enabled cycles only if next state is again PAT_W (OVERLAP=1 with a periodic pattern).
//   - Stays high while en=0 holds the state.
// - match_count increments on each edge where en=1 and next==PAT_W, i.e. on entry/re-entry, not per held cycle.
//   - Saturates at 2^CNT_W-1 (no wrap).
// - cnt_clr: count<=0; if an increment coincides, count<=1.
// - pat_load (priority over en): pattern<=pat_in, state<=0. match deasserts next cycle; count unaffected; data_in that cycle discarded.
// - Priority: rst > pat_load > en.
// - Out-of-range state (>PAT_W): next state 0.
// TESTING
// 1. Default 11011, OVERLAP=1, en=1, stream 1,1,0,1,1,0,1,1:
//    match=1 after bit 5 and after bit 8; state after bit 5=5 then 3,4,5; count=2.
// 2. Same stream, OVERLAP=0 instance: one match after bit 5; state after bit 8=2; count=1.
// 3. Stream 1,1,1,0,1,1: state sequence 1,2,2,3,4,5; match only after bit 6; count=1.
// 4. pat_load with pat_in=5'b10100 when state=3: state=0 next cycle.
//    Then 1,0,1,0,0 gives match after bit 5; count +1. Old pattern 11011 no longer matches.
// 5. en=0 for 3 cycles between bits 3 and 4 of 11011 while data_in toggles: state held at 3.
//    Match completes 2 enabled bits later. Held-match with en=0 for 4 cycles: count +1 only.
// 6. CNT_W=2, 4 matches: count 1,2,3,3.
//    cnt_clr coincident with a match: count=1.
//    rst at state 4: next cycle state=0, count=0, pattern=11011.

Source files
------------

// File: rtl/seq_detect_moore_param.sv
// rtl/seq_detect_moore_param.sv - Parametrised Moore serial sequence detector with loadable pattern
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   en           in   1      sample enable; data_in consumed only when en=1
//   data_in      in   1      serial input bit
//   pat_load     in   1      load pat_in as the active pattern (restarts matching)
//   pat_in       in   PAT_W  new pattern, MSB is the first bit received
//   cnt_clr      in   1      clear match_count
//   match        out  1      high while the full pattern is matched (decoded from state)
//   match_count  out  CNT_W  saturating count of match entries
//   state        out  ST_W   number of pattern bits currently matched (0..PAT_W)

module seq_detect_moore_param #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b11011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8,
    localparam int              ST_W    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data_in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [ST_W-1:0]  state
);

    // S is at most PAT_W+1 bits long (full match plus the new bit).
    localparam int SW = PAT_W + 1;

    logic [PAT_W-1:0] pat_q;
    logic [ST_W-1:0]  state_q;
    logic [ST_W-1:0]  state_d;
    logic [ST_W-1:0]  kmp_next;
    logic [CNT_W-1:0] cnt_q;
    logic             inc;

    // Failure-function-free KMP step: build S = (first k pattern bits, b) as a
    // number with b in the LSB, then keep the longest j whose low j bits equal
    // the top j pattern bits. Evaluated directly against the pattern register
    // so a freshly loaded pattern needs no precomputed table.
    always_comb begin
        int            k;
        int            best;
        logic [SW-1:0] s_val;
        logic [SW-1:0] mask;
        logic [SW-1:0] pre;

        k = int'(state_q);
        if (!OVERLAP && k == PAT_W) begin
            k = 0;
        end
        best  = 0;
        s_val = '0;
        mask  = '0;
        pre   = '0;
        if (k <= PAT_W) begin
            s_val = {pat_q >> (PAT_W - k), data_in};
            for (int j = 1; j <= PAT_W; j++) begin
                if (j <= k + 1) begin
                    mask = (SW'(1) << j) - SW'(1);
                    pre  = SW'(pat_q >> (PAT_W - j));
                    if ((s_val & mask) == pre) begin
                        best = j;
                    end
                end
            end
        end
        kmp_next = ST_W'(best);
    end

    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        if (pat_load) begin
            state_d = '0;
        end else if (int'(state_q) > PAT_W) begin
            // Unreachable encodings recover to the idle state.
            state_d = '0;
        end else if (en) begin
            state_d = kmp_next;
            inc     = (kmp_next == ST_W'(PAT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            pat_q   <= PATTERN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pat_load) begin
                pat_q <= pat_in;
            end
            // A match entry in the same cycle as a clear is not lost.
            if (cnt_clr) begin
                cnt_q <= inc ? CNT_W'(1) : '0;
            end else if (inc && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign match       = (state_q == ST_W'(PAT_W));
    assign match_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// tb/tb_seq_detect_moore_param.sv - Self-checking bench for seq_detect_moore_param

module tb_seq_detect_moore_param;

    logic       clk = 1'b0;
    logic       rst, en, data_in, pat_load, cnt_clr;
    logic [4:0] pat_in;

    logic       m0, m1, m2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic [2:0] s0, s1, s2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults (overlap). Instance 1: no overlap. Instance 2: 2-bit counter.
    seq_detect_moore_param dut_ov (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .match(m0), .match_count(c0), .state(s0)
    );
    seq_detect_moore_param #(.OVERLAP(1'b0)) dut_no (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .match(m1), .match_count(c1), .state(s1)
    );
    seq_detect_moore_param #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .match(m2), .match_count(c2), .state(s2)
    );

    // Reference model: bit history (newest bit in LSB) and its valid length.
    // State = longest prefix of the pattern that is a suffix of the history.
    int m_pat;
    int m_hist[3];
    int m_len[3];
    int m_st[3];
    int m_cnt[3];
    int m_ov[3]  = '{1, 0, 1};
    int m_max[3] = '{255, 255, 3};

    function automatic int longest(input int h, input int len, input int p);
        int lim;
        lim = (len < 5) ? len : 5;
        for (int j = lim; j >= 1; j--) begin
            if ((h & ((1 << j) - 1)) == (p >> (5 - j))) return j;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int inc;
        for (int i = 0; i < 3; i++) begin
            inc = 0;
            if (rst) begin
                m_len[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_hist[i] = 0;
            end else begin
                if (pat_load) begin
                    m_len[i] = 0; m_st[i] = 0;
                end else if (en) begin
                    if (m_ov[i] == 0 && m_st[i] == 5) m_len[i] = 0;
                    m_hist[i] = ((m_hist[i] << 1) | int'(data_in)) & 31;
                    m_len[i]  = (m_len[i] < 5) ? m_len[i] + 1 : 5;
                    m_st[i]   = longest(m_hist[i], m_len[i], m_pat);
                    inc       = (m_st[i] == 5) ? 1 : 0;
                end
                if (cnt_clr) m_cnt[i] = inc;
                else if (inc == 1 && m_cnt[i] < m_max[i]) m_cnt[i]++;
            end
        end
        if (rst) m_pat = 5'b11011;
        else if (pat_load) m_pat = int'(pat_in);
    endtask

    task automatic step(input bit r, input bit pl, input logic [4:0] pi,
                        input bit e, input bit d, input bit cc);
        rst = r; pat_load = pl; pat_in = pi; en = e; data_in = d; cnt_clr = cc;
        @(posedge clk);
        model_update();
        #1;
        check("ov state", 32'(s0), 32'(m_st[0]));
        check("ov match", 32'(m0), 32'(m_st[0] == 5));
        check("ov count", 32'(c0), 32'(m_cnt[0]));
        check("no state", 32'(s1), 32'(m_st[1]));
        check("no match", 32'(m1), 32'(m_st[1] == 5));
        check("no count", 32'(c1), 32'(m_cnt[1]));
        check("c2 state", 32'(s2), 32'(m_st[2]));
        check("c2 match", 32'(m2), 32'(m_st[2] == 5));
        check("c2 count", 32'(c2), 32'(m_cnt[2]));
    endtask

    // Feed n enabled bits of v, MSB first.
    task automatic feed(input int n, input logic [31:0] v);
        for (int i = n - 1; i >= 0; i--) step(0, 0, 5'd0, 1, v[i], 0);
    endtask

    task automatic do_reset();
        step(1, 0, 5'd0, 0, 0, 0);
        step(1, 0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        m_pat = 5'b11011;
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = 0; m_len[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
        end
        do_reset();
        check("reset state", 32'(s0), 32'd0);
        check("reset count", 32'(c0), 32'd0);

        // Overlap vs non-overlap on 11011011.
        feed(8, 32'b11011011);
        check("t1 ov state", 32'(s0), 32'd5);
        check("t1 ov count", 32'(c0), 32'd2);
        check("t1 no state", 32'(s1), 32'd2);
        check("t1 no count", 32'(c1), 32'd1);

        // Partial-match fallback on 111011.
        do_reset();
        feed(3, 32'b111);
        check("t3 state after 111", 32'(s0), 32'd2);
        feed(3, 32'b011);
        check("t3 count", 32'(c0), 32'd1);

        // Pattern reload mid-match; old pattern must no longer match.
        do_reset();
        feed(3, 32'b110);
        step(0, 1, 5'b10100, 1, 1, 0);
        check("t4 state after load", 32'(s0), 32'd0);
        feed(5, 32'b10100);
        check("t4 new match", 32'(m0), 32'd1);
        feed(5, 32'b11011);
        check("t4 old no match", 32'(m0), 32'd0);
        check("t4 count", 32'(c0), 32'd1);

        // Enable gaps: hold partial state, then hold a match without recounting.
        do_reset();
        feed(3, 32'b110);
        for (int i = 0; i < 3; i++) step(0, 0, 5'd0, 0, i[0], 0);
        check("t5 held state", 32'(s0), 32'd3);
        feed(2, 32'b11);
        for (int i = 0; i < 4; i++) step(0, 0, 5'd0, 0, i[0], 0);
        check("t5 held match", 32'(m0), 32'd1);
        check("t5 count once", 32'(c0), 32'd1);

        // Saturation of the 2-bit counter, clear coinciding with a match, reset at state 4.
        do_reset();
        feed(14, 32'b11011011011011);
        check("t6 sat count", 32'(c2), 32'd3);
        feed(2, 32'b01);
        step(0, 0, 5'd0, 1, 1, 1);
        check("t6 clr+match", 32'(c2), 32'd1);
        do_reset();
        feed(4, 32'b1101);
        check("t6 state 4", 32'(s0), 32'd4);
        step(1, 0, 5'd0, 1, 1, 0);
        check("t6 rst state", 32'(s0), 32'd0);
        check("t6 rst count", 32'(c0), 32'd0);
        feed(5, 32'b11011);
        check("t6 default pattern", 32'(m0), 32'd1);

        // Randomized traffic, including periodic patterns.
        for (int n = 0; n < 4000; n++) begin
            logic [4:0] p;
            int sel;
            sel = int'($urandom_range(0, 3));
            p = (sel == 0) ? 5'b11111 : (sel == 1) ? 5'b10101 : 5'($urandom);
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 119) == 0), p,
                 ($urandom_range(0, 4) != 0),
                 1'($urandom),
                 ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
